imem_port_arbiter: RTL and testbench

Arbitrates the single-ported instruction memory (word window 0x6300_0000–0x6300_00FC) between the core's instruction-fetch port and the program-loader port. After reset it holds fetch off until the loader signals boot completion. It then shares the memory round-robin. It performs the address-window and alignment check on every access and returns registered read data with per-requester valid and error flags.

---
 rtl/imem_port_arbiter_if.sv | 43 ++++
 rtl/imem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_port_arbiter_if.sv
// Bundle of requester, boot-control and memory-side signals for imem_port_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it (requesters plus memory).
interface imem_port_arbiter_if #(
  parameter int WIDTH_DATA = 32
);
  logic                  f_req;
  logic [WIDTH_DATA-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [WIDTH_DATA-1:0] f_rdata;
  logic                  f_err;

  logic                  l_req;
  logic                  l_we;
  logic [WIDTH_DATA-1:0] l_addr;
  logic [WIDTH_DATA-1:0] l_wdata;
  logic                  l_gnt;
  logic                  l_rvalid;
  logic [WIDTH_DATA-1:0] l_rdata;
  logic                  l_err;

  logic                  boot_done;
  logic                  running;

  logic [WIDTH_DATA-1:0] m_addr;
  logic                  m_we;
  logic [WIDTH_DATA-1:0] m_wdata;
  logic [WIDTH_DATA-1:0] m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, boot_done, m_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output m_addr, m_we, m_wdata, running
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, boot_done, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  m_addr, m_we, m_wdata, running
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a single-ported instruction memory between fetch and program loader:
// loader-only during BOOT, round-robin in RUN, with window/alignment checking and registered responses.
module imem_port_arbiter #(
  parameter int                    WIDTH_DATA = 32,
  parameter logic [WIDTH_DATA-1:0] BASE_ADDR  = 32'h6300_0000,
  parameter logic [WIDTH_DATA-1:0] LAST_ADDR  = 32'h6300_00FC
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_port_arbiter_if.slave  bus
);

  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;
  typedef enum logic {WIN_FETCH = 1'b0, WIN_LOADER = 1'b1} win_t;

  state_t r_state, w_state_nxt;
  win_t   r_last_win, w_last_win_nxt;

  logic w_f_gnt, w_l_gnt;
  logic w_f_legal, w_l_legal;

  logic [WIDTH_DATA-1:0] w_m_addr, w_m_wdata;
  logic                  w_m_we;

  logic                  r_f_rvalid, r_f_err;
  logic [WIDTH_DATA-1:0] r_f_rdata;
  logic                  r_l_rvalid, r_l_err;
  logic [WIDTH_DATA-1:0] r_l_rdata;

  function automatic logic addr_legal(input logic [WIDTH_DATA-1:0] addr);
    return (addr >= BASE_ADDR) && (addr <= LAST_ADDR) && (addr[1:0] == 2'b00);
  endfunction

  assign w_f_legal = addr_legal(bus.f_addr);
  assign w_l_legal = addr_legal(bus.l_addr);

  // Next state and grants. Under contention the requester that did not win last time is served.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_last_win_nxt = r_last_win;
    w_f_gnt        = 1'b0;
    w_l_gnt        = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_l_gnt = bus.l_req;
        if (bus.boot_done) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.f_req && bus.l_req) begin
          if (r_last_win == WIN_LOADER) w_f_gnt = 1'b1;
          else                          w_l_gnt = 1'b1;
        end else begin
          w_f_gnt = bus.f_req;
          w_l_gnt = bus.l_req;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
    if (w_f_gnt)      w_last_win_nxt = WIN_FETCH;
    else if (w_l_gnt) w_last_win_nxt = WIN_LOADER;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it only takes effect at a rising edge with rst_n low.
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_last_win <= WIN_LOADER;
    end else begin
      r_state    <= w_state_nxt;
      r_last_win <= w_last_win_nxt;
    end
  end

  // Memory port follows the granted requester; illegal writes never reach the array.
  always_comb begin
    w_m_addr  = '0;
    w_m_we    = 1'b0;
    w_m_wdata = '0;
    if (w_f_gnt) begin
      w_m_addr = bus.f_addr;
    end else if (w_l_gnt) begin
      w_m_addr = bus.l_addr;
      w_m_we   = bus.l_we && w_l_legal;
      if (bus.l_we) w_m_wdata = bus.l_wdata;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (!rst_n) begin
      r_f_rvalid <= 1'b0;
      r_f_err    <= 1'b0;
      r_f_rdata  <= '0;
      r_l_rvalid <= 1'b0;
      r_l_err    <= 1'b0;
      r_l_rdata  <= '0;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_f_err    <= w_f_gnt && !w_f_legal;
      r_f_rdata  <= (w_f_gnt && w_f_legal) ? bus.m_rdata : '0;
      r_l_rvalid <= w_l_gnt;
      r_l_err    <= w_l_gnt && !w_l_legal;
      r_l_rdata  <= (w_l_gnt && w_l_legal && !bus.l_we) ? bus.m_rdata : '0;
    end
  end

  assign bus.f_gnt    = w_f_gnt;
  assign bus.l_gnt    = w_l_gnt;
  assign bus.m_addr   = w_m_addr;
  assign bus.m_we     = w_m_we;
  assign bus.m_wdata  = w_m_wdata;
  assign bus.running  = (r_state == ST_RUN);
  assign bus.f_rvalid = r_f_rvalid;
  assign bus.f_err    = r_f_err;
  assign bus.f_rdata  = r_f_rdata;
  assign bus.l_rvalid = r_l_rvalid;
  assign bus.l_err    = r_l_err;
  assign bus.l_rdata  = r_l_rdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the arbiter and its memory.
module tb_imem_port_arbiter;

  localparam logic [31:0] BASE = 32'h6300_0000;
  localparam logic [31:0] LAST = 32'h6300_00FC;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  imem_port_arbiter_if bus ();

  imem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory: combinational read, write at the rising edge.
  logic [31:0] mem [64];
  assign bus.m_rdata = (bus.m_addr >= BASE && bus.m_addr <= LAST) ?
                       mem[bus.m_addr[7:2]] : {16'hBAD0, bus.m_addr[15:0]};
  always @(posedge clk) if (bus.m_we) mem[bus.m_addr[7:2]] <= bus.m_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a >= BASE) && (a <= LAST) && (a[1:0] == 2'b00);
  endfunction

  // Reference model: mode, who was served last, a copy of the memory, and the promised responses.
  bit          m_run = 0;
  bit          m_last_loader = 1;
  logic [31:0] ref_mem [64];
  bit          p_f_v = 0, p_f_err = 0, p_l_v = 0, p_l_err = 0;
  logic [31:0] p_f_data = '0, p_l_data = '0;
  bit          eg_f, eg_l, e_we;
  logic [31:0] e_addr, e_wdata;

  always @(negedge clk) begin
    eg_f = 0;
    eg_l = 0;
    if (!m_run)                        eg_l = bus.l_req;
    else if (bus.f_req && bus.l_req)   begin eg_f = m_last_loader; eg_l = !m_last_loader; end
    else                               begin eg_f = bus.f_req; eg_l = bus.l_req; end
    e_addr  = eg_f ? bus.f_addr : (eg_l ? bus.l_addr : 32'h0);
    e_we    = eg_l && bus.l_we && legal(bus.l_addr);
    e_wdata = (eg_l && bus.l_we) ? bus.l_wdata : 32'h0;

    check("m.f_gnt", 32'(bus.f_gnt), 32'(eg_f));
    check("m.l_gnt", 32'(bus.l_gnt), 32'(eg_l));
    check("m.m_addr", bus.m_addr, e_addr);
    check("m.m_we", 32'(bus.m_we), 32'(e_we));
    check("m.m_wdata", bus.m_wdata, e_wdata);
    check("m.running", 32'(bus.running), 32'(m_run));
    check("m.f_rvalid", 32'(bus.f_rvalid), 32'(p_f_v));
    check("m.l_rvalid", 32'(bus.l_rvalid), 32'(p_l_v));
    if (p_f_v) begin
      check("m.f_err", 32'(bus.f_err), 32'(p_f_err));
      check("m.f_rdata", bus.f_rdata, p_f_data);
    end
    if (p_l_v) begin
      check("m.l_err", 32'(bus.l_err), 32'(p_l_err));
      check("m.l_rdata", bus.l_rdata, p_l_data);
    end

    // Outcome of the coming edge.
    p_f_v    = rst_n && eg_f;
    p_f_err  = !legal(bus.f_addr);
    p_f_data = legal(bus.f_addr) ? ref_mem[bus.f_addr[7:2]] : 32'h0;
    p_l_v    = rst_n && eg_l;
    p_l_err  = !legal(bus.l_addr);
    p_l_data = (legal(bus.l_addr) && !bus.l_we) ? ref_mem[bus.l_addr[7:2]] : 32'h0;
    if (e_we) ref_mem[bus.l_addr[7:2]] = bus.l_wdata;
    if (!rst_n) begin
      m_run = 0;
      m_last_loader = 1;
    end else begin
      if (eg_f)      m_last_loader = 0;
      else if (eg_l) m_last_loader = 1;
      if (bus.boot_done) m_run = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : LAST + 32'd4;
    if (r == 1) return BASE + 32'($urandom_range(0, 255));
    return BASE + 32'($urandom_range(0, 63)) * 4;
  endfunction

  task automatic idle_inputs();
    bus.f_req = 0; bus.f_addr = '0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;
    bus.boot_done = 0;
  endtask

  initial begin
    bit fg, lg;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      ref_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    end
    rst_n = 0;
    idle_inputs();
    step(); step();

    // BOOT holds fetch off.
    rst_n = 1;
    bus.f_req = 1; bus.f_addr = BASE;
    @(negedge clk);
    check("rst.f_rvalid", 32'(bus.f_rvalid), 32'h0);
    check("rst.f_rdata", bus.f_rdata, 32'h0);
    check("rst.m_addr", bus.m_addr, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("boot.f_gnt", 32'(bus.f_gnt), 32'h0);
      check("boot.running", 32'(bus.running), 32'h0);
      check("boot.f_rvalid", 32'(bus.f_rvalid), 32'h0);
      step();
    end

    // Loader write during BOOT, then boot_done.
    idle_inputs();
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h6300_0010; bus.l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ldw.l_gnt", 32'(bus.l_gnt), 32'h1);
    check("ldw.m_we", 32'(bus.m_we), 32'h1);
    step();
    idle_inputs();
    bus.boot_done = 1;
    @(negedge clk);
    check("ldw.l_rvalid", 32'(bus.l_rvalid), 32'h1);
    check("ldw.l_rdata", bus.l_rdata, 32'h0);
    step();
    idle_inputs();
    bus.f_req = 1; bus.f_addr = 32'h6300_0010;
    @(negedge clk);
    check("run.running", 32'(bus.running), 32'h1);
    check("fr.f_gnt", 32'(bus.f_gnt), 32'h1);
    step();
    idle_inputs();
    bus.l_req = 1; bus.l_addr = 32'h6300_0020;   // loader read leaves loader as last winner
    @(negedge clk);
    check("fr.f_rvalid", 32'(bus.f_rvalid), 32'h1);
    check("fr.f_rdata", bus.f_rdata, 32'hDEAD_BEEF);
    check("fr.f_err", 32'(bus.f_err), 32'h0);
    step();

    // Continuous contention alternates, fetch first.
    bus.f_req = 1; bus.f_addr = 32'h6300_0030;
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h6300_0040;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr.f_gnt", 32'(bus.f_gnt), 32'(k % 2 == 0));
      check("rr.l_gnt", 32'(bus.l_gnt), 32'(k % 2 == 1));
      if (k > 0) check("rr.f_rvalid", 32'(bus.f_rvalid), 32'((k - 1) % 2 == 0));
      step();
    end
    idle_inputs();
    @(negedge clk);
    check("rr.l_rvalid_last", 32'(bus.l_rvalid), 32'h1);
    step();

    // Illegal loader write above window and misaligned fetch.
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h6300_0100; bus.l_wdata = 32'h1234_5678;
    bus.f_req = 1; bus.f_addr = 32'h6300_0002;
    @(negedge clk);
    check("ill.f_gnt", 32'(bus.f_gnt), 32'h1);
    step();
    bus.f_req = 0;
    @(negedge clk);
    check("ill.l_gnt", 32'(bus.l_gnt), 32'h1);
    check("ill.m_we", 32'(bus.m_we), 32'h0);
    check("ill.f_err", 32'(bus.f_err), 32'h1);
    check("ill.f_rdata", bus.f_rdata, 32'h0);
    step();
    idle_inputs();
    @(negedge clk);
    check("ill.l_rvalid", 32'(bus.l_rvalid), 32'h1);
    check("ill.l_err", 32'(bus.l_err), 32'h1);
    check("ill.l_rdata", bus.l_rdata, 32'h0);
    step();

    // Window boundaries.
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = LAST; bus.l_wdata = 32'hCAFE_F00D;
    step();
    idle_inputs();
    bus.f_req = 1; bus.f_addr = LAST;
    step();
    bus.f_addr = 32'h62FF_FFFC;
    @(negedge clk);
    check("bnd.top_err", 32'(bus.f_err), 32'h0);
    check("bnd.top_data", bus.f_rdata, 32'hCAFE_F00D);
    step();
    idle_inputs();
    @(negedge clk);
    check("bnd.low_rvalid", 32'(bus.f_rvalid), 32'h1);
    check("bnd.low_err", 32'(bus.f_err), 32'h1);
    step();

    // Reset right after a granted fetch.
    bus.f_req = 1; bus.f_addr = 32'h6300_0004;
    step();
    bus.f_req = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    bus.f_req = 1;
    @(negedge clk);
    check("rstp.f_rvalid", 32'(bus.f_rvalid), 32'h0);
    check("rstp.running", 32'(bus.running), 32'h0);
    check("rstp.f_gnt", 32'(bus.f_gnt), 32'h0);
    step();

    // Randomized traffic; requests hold until granted, occasionally withdrawn.
    idle_inputs();
    fg = 0; lg = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!(bus.f_req && !fg && $urandom_range(0, 15) != 0)) begin
        bus.f_req  = ($urandom_range(0, 2) != 0);
        bus.f_addr = rand_addr();
      end
      if (!(bus.l_req && !lg && $urandom_range(0, 15) != 0)) begin
        bus.l_req   = ($urandom_range(0, 2) != 0);
        bus.l_we    = ($urandom_range(0, 1) != 0);
        bus.l_addr  = rand_addr();
        bus.l_wdata = $urandom;
      end
      bus.boot_done = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
      fg = bus.f_gnt;
      lg = bus.l_gnt;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
